// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, link index and register types for the register file slice
package regfile_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_LINK_REG = 15;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read/write/swap/issue bus between decode/writeback and the register file
interface regfile_sb_if import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [ADDR_W-1:0] rd_addr0, rd_addr1, wr0_addr, wr1_addr, issue_addr;
  logic [DATA_W-1:0] rd_data0, rd_data1, link_data, wr0_data, wr1_data;
  logic wr0_en, wr1_en, swap_en, issue_en;
  logic busy0, busy1, stall, wr_collide, swap_err;
  modport master (
    output rd_addr0, rd_addr1, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    output swap_en, issue_en, issue_addr,
    input rd_data0, rd_data1, link_data, busy0, busy1, stall, wr_collide, swap_err
  );
  modport slave (
    input rd_addr0, rd_addr1, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    input swap_en, issue_en, issue_addr,
    output rd_data0, rd_data1, link_data, busy0, busy1, stall, wr_collide, swap_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with set-over-clear priority, busy and stall
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter bit BYPASS = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic              swap_en,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              busy0,
  output logic              busy1,
  output logic              stall,
  output logic              swap_ok
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DEPTH-1:0] pend, clr, eff, nxt;
  logic set;
  // busy sees the raw write clears so swap acceptance cannot loop back through write gating
  always_comb begin
    clr = '0;
    if (wr0_en) clr[wr0_addr] = 1'b1;
    if (wr1_en) clr[wr1_addr] = 1'b1;
    eff = BYPASS ? pend & ~clr : pend;
    busy0 = eff[rd_addr0];
    busy1 = eff[rd_addr1];
    stall = issue_en & (busy0 | busy1 | eff[issue_addr]);
    swap_ok = swap_en & ~busy0 & ~busy1;
    set = issue_en & ~stall & ~(ZERO_REG && issue_addr == '0);
    nxt = swap_ok ? pend : pend & ~clr;
    if (set) nxt[issue_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) pend <= '0;
    else pend <= nxt;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/2W register file with swap, optional bypass and a pending-write scoreboard
module regfile_sb import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINK_REG = DEF_LINK_REG,
  parameter bit BYPASS = 1'b1,
  parameter bit ZERO_REG = 1'b0,
  parameter logic [(2**ADDR_W)*DATA_W-1:0] RST_VAL = '0
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] link_addr;
  logic w0, w1, swap_ok, same;
  function automatic logic is_z(input logic [ADDR_W-1:0] a);
    return ZERO_REG && a == '0;
  endfunction
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    return is_z(a) ? '0 :
           (BYPASS && !swap_ok && w0 && bus.wr0_addr == a) ? bus.wr0_data :
           (BYPASS && !swap_ok && w1 && bus.wr1_addr == a) ? bus.wr1_data : regs[a];
  endfunction
  assign link_addr = ADDR_W'(LINK_REG);
  assign same = bus.wr0_en & bus.wr1_en & (bus.wr0_addr == bus.wr1_addr);
  assign w0 = bus.wr0_en & ~is_z(bus.wr0_addr);
  assign w1 = bus.wr1_en & ~is_z(bus.wr1_addr) & ~same;
  assign bus.rd_data0 = rd(bus.rd_addr0);
  assign bus.rd_data1 = rd(bus.rd_addr1);
  assign bus.link_data = rd(link_addr);
  regfile_scoreboard #(.ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk), .rst(rst),
    .rd_addr0(bus.rd_addr0), .rd_addr1(bus.rd_addr1),
    .wr0_en(w0), .wr0_addr(bus.wr0_addr), .wr1_en(w1), .wr1_addr(bus.wr1_addr),
    .swap_en(bus.swap_en), .issue_en(bus.issue_en), .issue_addr(bus.issue_addr),
    .busy0(bus.busy0), .busy1(bus.busy1), .stall(bus.stall), .swap_ok(swap_ok)
  );
  // bypass is off during a swap, so rd_data* carry the stored pre-edge values
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RST_VAL[i*DATA_W +: DATA_W];
    end else if (swap_ok) begin
      if (bus.rd_addr0 != bus.rd_addr1 && !is_z(bus.rd_addr1)) regs[bus.rd_addr1] <= bus.rd_data0;
      if (bus.rd_addr0 != bus.rd_addr1 && !is_z(bus.rd_addr0)) regs[bus.rd_addr0] <= bus.rd_data1;
    end else begin
      if (w1) regs[bus.wr1_addr] <= bus.wr1_data;
      if (w0) regs[bus.wr0_addr] <= bus.wr0_data;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.wr_collide <= 1'b0;
      bus.swap_err <= 1'b0;
    end else begin
      bus.wr_collide <= same & ~swap_ok;
      bus.swap_err <= bus.swap_en & ~swap_ok;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table plus hand sequences for bypass, link and busy timing
module tb_regfile_sb;
  import regfile_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  localparam logic [255:0] RV = (256'h0F00 << 16) | (256'h0002 << 208);
  regfile_sb_if ifa ();
  regfile_sb_if ifb ();
  assign ifb.rd_addr0 = ifa.rd_addr0;
  assign ifb.rd_addr1 = ifa.rd_addr1;
  assign ifb.wr0_en = ifa.wr0_en;
  assign ifb.wr0_addr = ifa.wr0_addr;
  assign ifb.wr0_data = ifa.wr0_data;
  assign ifb.wr1_en = ifa.wr1_en;
  assign ifb.wr1_addr = ifa.wr1_addr;
  assign ifb.wr1_data = ifa.wr1_data;
  assign ifb.swap_en = ifa.swap_en;
  assign ifb.issue_en = ifa.issue_en;
  assign ifb.issue_addr = ifa.issue_addr;
  regfile_sb #(.BYPASS(1'b1), .RST_VAL(RV)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  regfile_sb #(.BYPASS(1'b0), .RST_VAL(RV)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  typedef struct {
    logic r;
    reg_addr_t a0, a1;
    logic w0e;
    reg_addr_t w0a;
    reg_data_t w0d;
    logic w1e;
    reg_addr_t w1a;
    reg_data_t w1d;
    logic sw, ie;
    reg_addr_t ia;
    reg_data_t d0, d1;
    logic [4:0] fl;
  } vec_t;
  localparam int NV = 21;
  vec_t v [NV];
  int n = 0;
  int errs = 0;
  function automatic vec_t mk(logic r, reg_addr_t a0, reg_addr_t a1, logic w0e, reg_addr_t w0a,
                              reg_data_t w0d, logic w1e, reg_addr_t w1a, reg_data_t w1d, logic sw,
                              logic ie, reg_addr_t ia, reg_data_t d0, reg_data_t d1, logic [4:0] fl);
    vec_t x;
    x.r = r; x.a0 = a0; x.a1 = a1; x.w0e = w0e; x.w0a = w0a; x.w0d = w0d;
    x.w1e = w1e; x.w1a = w1a; x.w1d = w1d; x.sw = sw; x.ie = ie; x.ia = ia;
    x.d0 = d0; x.d1 = d1; x.fl = fl;
    return x;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t x);
    rst = x.r;
    ifa.rd_addr0 = x.a0; ifa.rd_addr1 = x.a1;
    ifa.wr0_en = x.w0e; ifa.wr0_addr = x.w0a; ifa.wr0_data = x.w0d;
    ifa.wr1_en = x.w1e; ifa.wr1_addr = x.w1a; ifa.wr1_data = x.w1d;
    ifa.swap_en = x.sw; ifa.issue_en = x.ie; ifa.issue_addr = x.ia;
  endtask
  task automatic idle();
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask
  initial begin
    // fl = {busy0, busy1, stall, wr_collide, swap_err}
    v[0]  = mk(0, 1, 13, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0F00, 16'h0002, 5'b00000);
    v[1]  = mk(1, 3, 3, 1, 3, 16'hAAAA, 1, 3, 16'h5555, 0, 0, 0, 16'hAAAA, 16'hAAAA, 5'b00000);
    v[2]  = mk(1, 3, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'hAAAA, 16'hAAAA, 5'b00010);
    v[3]  = mk(1, 5, 3, 1, 5, 16'h1234, 0, 0, 16'h0000, 0, 0, 0, 16'h1234, 16'hAAAA, 5'b00000);
    v[4]  = mk(1, 5, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h1234, 16'h0F00, 5'b00000);
    v[5]  = mk(1, 2, 7, 1, 2, 16'h0050, 1, 7, 16'h00FF, 0, 0, 0, 16'h0050, 16'h00FF, 5'b00000);
    v[6]  = mk(1, 2, 7, 1, 2, 16'h9999, 0, 0, 16'h0000, 1, 0, 0, 16'h0050, 16'h00FF, 5'b00000);
    v[7]  = mk(1, 2, 7, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h00FF, 16'h0050, 5'b00000);
    v[8]  = mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 4, 16'h0000, 16'h0000, 5'b00000);
    v[9]  = mk(1, 4, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 8, 16'h0000, 16'h0000, 5'b10100);
    v[10] = mk(1, 4, 0, 1, 4, 16'h4444, 0, 0, 16'h0000, 0, 1, 8, 16'h4444, 16'h0000, 5'b00000);
    v[11] = mk(1, 8, 4, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h4444, 5'b10000);
    v[12] = mk(1, 8, 5, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h1234, 5'b10000);
    v[13] = mk(1, 8, 5, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h1234, 5'b10001);
    v[14] = mk(1, 8, 5, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h1234, 5'b10000);
    v[15] = mk(1, 0, 0, 1, 8, 16'h8888, 0, 0, 16'h0000, 0, 1, 8, 16'h0000, 16'h0000, 5'b00000);
    v[16] = mk(1, 8, 2, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h8888, 16'h00FF, 5'b10000);
    v[17] = mk(0, 8, 2, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 5'b00000);
    v[18] = mk(1, 1, 13, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0F00, 16'h0002, 5'b00000);
    v[19] = mk(1, 13, 8, 0, 0, 16'h0000, 1, 13, 16'h1313, 0, 0, 0, 16'h1313, 16'h0000, 5'b00000);
    v[20] = mk(1, 13, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h1313, 16'h0000, 5'b00000);
    drive(v[0]);
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(v[i]);
      #1;
      chk($sformatf("v%0d rd_data0", i), 32'(ifa.rd_data0), 32'(v[i].d0));
      chk($sformatf("v%0d rd_data1", i), 32'(ifa.rd_data1), 32'(v[i].d1));
      chk($sformatf("v%0d flags", i),
          32'({ifa.busy0, ifa.busy1, ifa.stall, ifa.wr_collide, ifa.swap_err}), 32'(v[i].fl));
      if (i == 0) chk("reset link_data", 32'(ifa.link_data), 32'h0);
    end
    @(negedge clk);
    idle();
    ifa.wr0_en = 1; ifa.wr0_addr = 15; ifa.wr0_data = 16'hF00D;
    #1;
    chk("link bypass", 32'(ifa.link_data), 32'hF00D);
    chk("link nobypass pre", 32'(ifb.link_data), 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("link nobypass post", 32'(ifb.link_data), 32'hF00D);
    @(negedge clk);
    idle();
    ifa.rd_addr0 = 5; ifa.wr0_en = 1; ifa.wr0_addr = 5; ifa.wr0_data = 16'h5A5A;
    #1;
    chk("bypass rd_data0", 32'(ifa.rd_data0), 32'h5A5A);
    chk("nobypass rd_data0 pre", 32'(ifb.rd_data0), 32'h0);
    @(negedge clk);
    idle();
    ifa.rd_addr0 = 5;
    #1;
    chk("nobypass rd_data0 post", 32'(ifb.rd_data0), 32'h5A5A);
    @(negedge clk);
    idle();
    ifa.issue_en = 1; ifa.issue_addr = 9;
    #1;
    chk("issue r9 stall", 32'(ifa.stall), 32'h0);
    @(negedge clk);
    idle();
    ifa.rd_addr0 = 9; ifa.wr0_en = 1; ifa.wr0_addr = 9; ifa.wr0_data = 16'h0909;
    #1;
    chk("bypass busy0 clear", 32'(ifa.busy0), 32'h0);
    chk("nobypass busy0 held", 32'(ifb.busy0), 32'h1);
    @(negedge clk);
    idle();
    ifa.rd_addr0 = 9;
    #1;
    chk("nobypass busy0 after", 32'(ifb.busy0), 32'h0);
    chk("nobypass r9 data", 32'(ifb.rd_data0), 32'h0909);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
